// File: rtl/ssram_line_master_if.sv
// SRAM-side bus of ssram_line_master: enable, write, address and write data
// towards the synchronous single-port SRAM, and read data back from it.
// The master modport belongs to the line master, the slave modport to the SRAM.
interface ssram_line_master_if #(
  parameter int AW = 18,
  parameter int DW = 32
);

  logic          oMemEnable;
  logic          oMemWr;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic [DW-1:0] iMemRData;

  modport master (
    output oMemEnable,
    output oMemWr,
    output oMemAddr,
    output oMemWData,
    input  iMemRData
  );

  modport slave (
    input  oMemEnable,
    input  oMemWr,
    input  oMemAddr,
    input  oMemWData,
    output iMemRData
  );

endinterface

// File: rtl/ssram_line_master.sv
// ssram_line_master: turns whole-cache-line read/write requests into bursts of
// single-word accesses on a synchronous single-port SRAM with a registered
// address (read data appears the cycle after the address). Read words come
// back to the cache in issue order, two cycles after their beat, tagged with
// valid/last.
//
// Build option: define WRAP_BURST_EN for critical-word-first reads (the read
// starts at iReqAddr[LW-1:0] and wraps within the line). Without it every
// read starts at offset 0. Writes always start at offset 0.
module ssram_line_master #(
  parameter int AW = 18,
  parameter int DW = 32,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  // cache request side
  input  logic          iReq,
  input  logic          iReqWr,
  input  logic [AW-1:0] iReqAddr,
  output logic          oReqReady,
  input  logic [DW-1:0] iWrData,
  output logic          oWrDataAck,
  output logic          oRdValid,
  output logic [DW-1:0] oRdData,
  output logic          oRdLast,
  output logic          oBusy,
  // SRAM side
  ssram_line_master_if.master mem
);

`ifdef WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t         state;
  logic [AW-LW-1:0] base;       // line base, constant for the whole burst
  logic [LW-1:0]  cnt;          // word offset of the current beat
  logic [LW-1:0]  startOff;     // offset of the first beat of this burst
  logic [LW-1:0]  cntNext;
  logic [LW-1:0]  reqOff;
  logic           lastBeat;
  logic           active;
  logic           pipeValid;    // a read word is on iMemRData this cycle
  logic           pipeLast;     // ... and it is the final word of its line

  // The burst covers the line exactly once, so the final beat is the one
  // whose successor offset would bring us back to where we started.
  assign cntNext  = cnt + LW'(1);
  assign lastBeat = (cntNext == startOff);

  // Only wrapped reads honour the low address bits; writes start at 0.
  assign reqOff = (WrapEn && !iReqWr) ? iReqAddr[LW-1:0] : '0;

  // A reset asserted mid-burst must stop SRAM traffic in that very cycle,
  // not one edge later, so the SRAM strobes are qualified with rst_n.
  assign active = rst_n && (state != IDLE);

  assign oReqReady = (state == IDLE);
  assign oBusy     = (state != IDLE) || pipeValid || oRdValid;

  // Burst sequencer: accept in IDLE, then one beat per cycle for a full line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      startOff <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every register sees
      // pre-edge values; blocking would let later lines read updated ones.
      unique case (state)
        IDLE: begin
          if (iReq) begin
            base     <= iReqAddr[AW-1:LW];
            cnt      <= reqOff;
            startOff <= reqOff;
            state    <= iReqWr ? WR : RD;
          end
        end
        RD, WR: begin
          cnt <= cntNext;
          if (lastBeat) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return pipe: stage 1 marks the cycle the SRAM drives the word,
  // stage 2 captures it and presents it to the cache.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipeValid <= 1'b0;
      pipeLast  <= 1'b0;
      oRdValid  <= 1'b0;
      oRdLast   <= 1'b0;
      oRdData   <= '0;
    end else begin
      pipeValid <= (state == RD);
      pipeLast  <= (state == RD) && lastBeat;
      oRdValid  <= pipeValid;
      oRdLast   <= pipeLast;
      oRdData   <= pipeValid ? mem.iMemRData : '0;
    end
  end

  // SRAM strobes and write-data handshake, straight from state and cnt.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // assignment in combinational logic would infer a latch.
    mem.oMemEnable = 1'b0;
    mem.oMemWr     = 1'b0;
    mem.oMemAddr   = '0;
    mem.oMemWData  = '0;
    oWrDataAck     = 1'b0;
    if (active) begin
      mem.oMemEnable = 1'b1;
      mem.oMemAddr   = {base, cnt};
      if (state == WR) begin
        mem.oMemWr    = 1'b1;
        mem.oMemWData = iWrData;
        oWrDataAck    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssram_line_master.sv
// Directed self-checking bench for ssram_line_master with a behavioural
// registered-address SRAM. Expected values are hand-written constants.
// Define WRAP_BURST_EN for the critical-word-first build.
module tb_ssram_line_master;

`ifdef WRAP_BURST_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        iReq;
  logic        iReqWr;
  logic [17:0] iReqAddr;
  logic        oReqReady;
  logic [31:0] iWrData;
  logic        oWrDataAck;
  logic        oRdValid;
  logic [31:0] oRdData;
  logic        oRdLast;
  logic        oBusy;

  int checks;
  int failures;

  ssram_line_master_if #(.AW(18), .DW(32)) memBus ();

  ssram_line_master #(.AW(18), .DW(32), .LW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iReq       (iReq),
    .iReqWr     (iReqWr),
    .iReqAddr   (iReqAddr),
    .oReqReady  (oReqReady),
    .iWrData    (iWrData),
    .oWrDataAck (oWrDataAck),
    .oRdValid   (oRdValid),
    .oRdData    (oRdData),
    .oRdLast    (oRdLast),
    .oBusy      (oBusy),
    .mem        (memBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 256 words, registered address, read data next cycle.
  logic [31:0] sram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) sram[i] <= 32'h1000_0000 + 32'(i);
  end
  always @(posedge clk) begin
    if (memBus.oMemEnable) begin
      if (memBus.oMemWr) sram[memBus.oMemAddr[7:0]] <= memBus.oMemWData;
      else               memBus.iMemRData <= sram[memBus.oMemAddr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] startOf(input logic [17:0] a);
    return WrapEn ? a[1:0] : 2'b00;
  endfunction

  // Line write of four words; abortAt >= 0 pulls rst_n low on that beat.
  task automatic writeLine(input logic [17:0] addr, input logic [31:0] d[4], input int abortAt);
    logic [17:0] ea;
    iReq = 1'b1; iReqWr = 1'b1; iReqAddr = addr;
    @(negedge clk);
    check("wr_ready", oReqReady, 1);
    tick();
    iReq = 1'b0; iReqWr = 1'b0; iReqAddr = '0;
    for (int b = 0; b < 4; b++) begin
      iWrData = d[b];
      if (b == abortAt) rst_n = 1'b0;
      @(negedge clk);
      if (b == abortAt) begin
        check("rst_no_enable", memBus.oMemEnable, 0);
        check("rst_no_ack", oWrDataAck, 0);
        tick();
        rst_n = 1'b1;
        iWrData = '0;
        @(negedge clk);
        check("rst_ready", oReqReady, 1);
        check("rst_busy", oBusy, 0);
        check("rst_enable", memBus.oMemEnable, 0);
        check("rst_rdvalid", oRdValid, 0);
        check("rst_rddata", oRdData, 0);
        tick();
        return;
      end
      ea = {addr[17:2], 2'b00} + 18'(b);
      check("wr_enable", memBus.oMemEnable, 1);
      check("wr_wr", memBus.oMemWr, 1);
      check("wr_ack", oWrDataAck, 1);
      check("wr_addr", memBus.oMemAddr, ea);
      check("wr_data", memBus.oMemWData, d[b]);
      check("wr_ready_busy", oReqReady, 0);
      tick();
    end
    iWrData = '0;
    @(negedge clk);
    check("wr_idle_ready", oReqReady, 1);
    check("wr_idle_busy", oBusy, 0);
    check("wr_idle_enable", memBus.oMemEnable, 0);
  endtask

  // One or two line reads; the second is requested gap cycles after the first.
  task automatic readScript(input string tag, input logic [17:0] a0, input logic [17:0] a1,
                            input int nReq, input int gap, input logic [31:0] exp[8]);
    int          acc [2];
    logic [17:0] addrs [2];
    int          endCyc;
    int          words;
    logic        expValid, expLast, expRd;
    logic [31:0] expData;
    logic [17:0] expAddr;
    acc[0] = 0; acc[1] = gap;
    addrs[0] = a0; addrs[1] = a1;
    endCyc = acc[nReq-1] + 6;
    words = 0;
    for (int k = 0; k <= endCyc + 1; k++) begin
      expValid = 1'b0; expLast = 1'b0; expRd = 1'b0;
      expData = '0; expAddr = '0;
      iReq = 1'b0; iReqWr = 1'b0; iReqAddr = '0;
      for (int r = 0; r < nReq; r++) begin
        if (k == acc[r]) begin
          iReq = 1'b1;
          iReqAddr = addrs[r];
        end
        if (k >= acc[r] + 1 && k <= acc[r] + 4) begin
          expRd = 1'b1;
          expAddr = {addrs[r][17:2], 2'(startOf(addrs[r]) + 2'(k - acc[r] - 1))};
        end
        if (k >= acc[r] + 3 && k <= acc[r] + 6) begin
          expValid = 1'b1;
          expData = exp[r*4 + k - acc[r] - 3];
          expLast = (k == acc[r] + 6);
        end
      end
      @(negedge clk);
      if (iReq) check({tag, "_ready"}, oReqReady, 1);
      check({tag, "_busy"}, oBusy, (k >= 1 && k <= endCyc));
      check({tag, "_enable"}, memBus.oMemEnable, expRd);
      if (expRd) begin
        check({tag, "_memwr"}, memBus.oMemWr, 0);
        check({tag, "_addr"}, memBus.oMemAddr, expAddr);
      end
      check({tag, "_valid"}, oRdValid, expValid);
      check({tag, "_last"}, oRdLast, expLast);
      if (expValid) begin
        check({tag, "_data"}, oRdData, expData);
        if (oRdValid) words++;
      end
      tick();
    end
    iReq = 1'b0; iReqAddr = '0;
    check({tag, "_words"}, 64'(words), 64'(nReq * 4));
  endtask

  logic [31:0] wrA [4];
  logic [31:0] wrD [4];
  logic [31:0] e [8];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; iReq = 1'b0; iReqWr = 1'b0; iReqAddr = '0; iWrData = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset then idle.
    @(negedge clk);
    check("reset_ready", oReqReady, 1);
    check("reset_busy", oBusy, 0);
    check("reset_enable", memBus.oMemEnable, 0);
    check("reset_rdvalid", oRdValid, 0);
    check("reset_addr", memBus.oMemAddr, 0);
    tick();

    // Line write at 0x10.
    wrA = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    writeLine(18'h00010, wrA, -1);
    tick();

    // Read it back.
    e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0};
    readScript("rd10", 18'h00010, 18'h0, 1, 0, e);

    // Read from mid-line address 0x12: wrapped or linear order.
    if (WrapEn) e = '{32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'h0, 32'h0, 32'h0, 32'h0};
    else        e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0};
    readScript("rd12", 18'h00012, 18'h0, 1, 0, e);

    // Back-to-back reads of 0x10 and 0x20, second accepted 5 cycles later.
    e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3,
          32'h1000_0020, 32'h1000_0021, 32'h1000_0022, 32'h1000_0023};
    readScript("b2b", 18'h00010, 18'h00020, 2, 5, e);

    // Write 0x40 aborted by reset on the second beat: only 0x40 changes.
    wrD = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    writeLine(18'h00040, wrD, 1);
    e = '{32'hD0, 32'h1000_0041, 32'h1000_0042, 32'h1000_0043, 32'h0, 32'h0, 32'h0, 32'h0};
    readScript("rd40", 18'h00040, 18'h0, 1, 0, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
